// File: rtl/cache_line_store.sv
// cache_line_store: direct-mapped, write-through / no-write-allocate cache
// line store with a single outstanding line refill.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   req_valid/req_write   CPU request strobe and direction (1 = write)
//   req_addr/req_wdata    word address {tag, index, offset} and write data
//   req_ready             high only while idle; a request is taken on valid & ready
//   rsp_valid/rsp_hit     one-cycle response pulse and its hit result
//   rsp_rdata             read data for read responses (zero for writes)
//   fill_req/fill_addr    refill request and line base {tag, index, 0}
//   fill_valid/fill_data  refill beats, ascending word offset, only used in FILL
module cache_line_store #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 10,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_hit,
    output logic              fill_req,
    output logic [ADDR_W-1:0] fill_addr,
    input  logic              fill_valid,
    input  logic [WIDTH-1:0]  fill_data
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                      state_r;
    logic                        ready_r;
    logic [LINES-1:0]            valid_r;
    logic [TAG_W-1:0]            tag_mem_r  [LINES];
    logic [WIDTH-1:0]            data_mem_r [LINES*WORDS];
    logic [OFFSET_W-1:0]         beat_r;
    logic [TAG_W-1:0]            miss_tag_r;
    logic [INDEX_W-1:0]          miss_index_r;
    logic [OFFSET_W-1:0]         miss_offset_r;
    logic [WIDTH-1:0]            cap_data_r;
    logic                        rsp_valid_r;
    logic                        rsp_hit_r;
    logic [WIDTH-1:0]            rsp_rdata_r;
    logic                        fill_req_r;
    logic [ADDR_W-1:0]           fill_addr_r;

    logic [TAG_W-1:0]            req_tag_s;
    logic [INDEX_W-1:0]          req_index_s;
    logic [OFFSET_W-1:0]         req_offset_s;
    logic                        hit_s;
    logic                        accept_s;
    logic                        beat_last_s;
    logic                        beat_is_req_s;

    // Address split, hit lookup and handshake qualifiers.
    always_comb begin
        req_tag_s     = req_addr[ADDR_W-1 -: TAG_W];
        req_index_s   = req_addr[OFFSET_W +: INDEX_W];
        req_offset_s  = req_addr[OFFSET_W-1:0];
        hit_s         = 1'b0;
        if (valid_r[req_index_s] && (tag_mem_r[req_index_s] == req_tag_s)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        accept_s      = req_valid && ready_r;
        beat_last_s   = (beat_r == OFFSET_W'(WORDS - 1));
        beat_is_req_s = (beat_r == miss_offset_r);
    end

    // Control FSM, valid bits, beat counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            ready_r       <= 1'b1;
            valid_r       <= '0;
            beat_r        <= '0;
            miss_tag_r    <= '0;
            miss_index_r  <= '0;
            miss_offset_r <= '0;
            cap_data_r    <= {WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_hit_r     <= 1'b0;
            rsp_rdata_r   <= {WIDTH{1'b0}};
            fill_req_r    <= 1'b0;
            fill_addr_r   <= {ADDR_W{1'b0}};
        end else begin
            // Responses are single-cycle pulses unless re-armed below.
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (req_write) begin
                            rsp_valid_r <= 1'b1;
                            rsp_hit_r   <= hit_s;
                            rsp_rdata_r <= {WIDTH{1'b0}};
                        end else if (hit_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_hit_r   <= 1'b1;
                            rsp_rdata_r <= data_mem_r[{req_index_s, req_offset_s}];
                        end else begin
                            state_r       <= ST_FILL;
                            ready_r       <= 1'b0;
                            fill_req_r    <= 1'b1;
                            fill_addr_r   <= {req_tag_s, req_index_s, {OFFSET_W{1'b0}}};
                            miss_tag_r    <= req_tag_s;
                            miss_index_r  <= req_index_s;
                            miss_offset_r <= req_offset_s;
                            beat_r        <= '0;
                        end
                    end
                end
                ST_FILL: begin
                    if (fill_valid) begin
                        if (beat_is_req_s) begin
                            cap_data_r <= fill_data;
                        end
                        beat_r <= beat_r + OFFSET_W'(1);
                        if (beat_last_s) begin
                            valid_r[miss_index_r] <= 1'b1;
                            fill_req_r            <= 1'b0;
                            state_r               <= ST_RESP;
                            rsp_valid_r           <= 1'b1;
                            // The requested word may be arriving on this very beat.
                            rsp_rdata_r           <= beat_is_req_s ? fill_data : cap_data_r;
                        end
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ready_r    <= 1'b1;
                    fill_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Tag and word storage: deliberately not reset, qualified by valid_r.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if ((state_r == ST_IDLE) && accept_s && req_write && hit_s) begin
                data_mem_r[{req_index_s, req_offset_s}] <= req_wdata;
            end
            if ((state_r == ST_FILL) && fill_valid) begin
                data_mem_r[{miss_index_r, beat_r}] <= fill_data;
                if (beat_last_s) begin
                    tag_mem_r[miss_index_r] <= miss_tag_r;
                end
            end
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_hit   = rsp_hit_r;
    assign rsp_rdata = rsp_rdata_r;
    assign fill_req  = fill_req_r;
    assign fill_addr = fill_addr_r;

endmodule

// File: tb/tb_cache_line_store.sv
// Self-checking bench for cache_line_store: directed scenarios followed by
// randomized reads/writes, compared against an array-based cache model.
module tb_cache_line_store;

    localparam int WIDTH    = 32;
    localparam int ADDR_W   = 10;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int LINES    = 1 << INDEX_W;
    localparam int WORDS    = 1 << OFFSET_W;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_hit;
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_valid;
    logic [WIDTH-1:0]  fill_data;

    cache_line_store #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
        .fill_req(fill_req), .fill_addr(fill_addr),
        .fill_valid(fill_valid), .fill_data(fill_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the cache is supposed to hold.
    bit          m_valid [LINES];
    logic [2:0]  m_tag   [LINES];
    logic [31:0] m_data  [LINES][WORDS];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int a_idx(input logic [9:0] a);
        return int'(a[6:2]);
    endfunction

    function automatic int a_off(input logic [9:0] a);
        return int'(a[1:0]);
    endfunction

    function automatic bit m_hit(input logic [9:0] a);
        return m_valid[a_idx(a)] && (m_tag[a_idx(a)] == a[9:7]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [31:0] data);
        bit h;
        h = m_hit(addr);
        check_eq("wr_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        fill_valid = 1'($urandom_range(0, 1)); fill_data = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; fill_valid = 1'b0;
        if (h) m_data[a_idx(addr)][a_off(addr)] = data;
        check_eq("wr_rsp_valid", rsp_valid, 1);
        check_eq("wr_rsp_hit", rsp_hit, h);
        check_eq("wr_no_fill", fill_req, 0);
    endtask

    // Read; on a miss, serve the refill. Cycle i of the fill uses pat[i]
    // while i < plen, then random gaps (rgap) or continuous beats.
    task automatic do_read(input logic [9:0] addr, input logic [15:0] pat,
                           input int plen, input bit rgap);
        bit h;
        int beats, cyc, idx;
        bit fv;
        logic [31:0] line [WORDS];
        h   = m_hit(addr);
        idx = a_idx(addr);
        check_eq("rd_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_wdata = $urandom;
        fill_valid = 1'($urandom_range(0, 1)); fill_data = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0; fill_valid = 1'b0;
        if (h) begin
            check_eq("rd_hit_valid", rsp_valid, 1);
            check_eq("rd_hit_flag", rsp_hit, 1);
            check_eq("rd_hit_data", rsp_rdata, m_data[idx][a_off(addr)]);
        end else begin
            check_eq("rd_miss_no_rsp", rsp_valid, 0);
            check_eq("fill_req_start", fill_req, 1);
            check_eq("fill_addr", fill_addr, {addr[9:2], 2'b00});
            check_eq("fill_not_ready", req_ready, 0);
            beats = 0;
            cyc   = 0;
            while (beats < WORDS && cyc < 64) begin
                if (cyc < plen) fv = pat[cyc];
                else if (rgap)  fv = 1'($urandom_range(0, 1));
                else            fv = 1'b1;
                fill_valid = fv;
                fill_data  = $urandom;
                check_eq("fill_req_held", fill_req, 1);
                check_eq("fill_ready_low", req_ready, 0);
                check_eq("fill_no_rsp", rsp_valid, 0);
                @(posedge clk);
                if (fv) begin
                    line[beats] = fill_data;
                    beats++;
                end
                #1;
                cyc++;
            end
            fill_valid = 1'b0;
            check_eq("fill_beats", beats, WORDS);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = addr[9:7];
            for (int k = 0; k < WORDS; k++) m_data[idx][k] = line[k];
            check_eq("resp_valid", rsp_valid, 1);
            check_eq("resp_hit", rsp_hit, 0);
            check_eq("resp_data", rsp_rdata, line[a_off(addr)]);
            check_eq("resp_fill_drop", fill_req, 0);
            check_eq("resp_ready_low", req_ready, 0);
            @(posedge clk); #1;
            check_eq("resp_once", rsp_valid, 0);
            check_eq("resp_back_idle", req_ready, 1);
        end
    endtask

    // Start a miss, deliver nb beats, then reset in the middle of the refill.
    task automatic read_abort(input logic [9:0] addr, input int nb);
        check_eq("abort_pre_miss", m_hit(addr), 0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("abort_fill_req", fill_req, 1);
        for (int i = 0; i < nb; i++) begin
            fill_valid = 1'b1; fill_data = $urandom;
            @(posedge clk); #1;
        end
        fill_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_fill_req_low", fill_req, 0);
        check_eq("abort_rsp_valid", rsp_valid, 0);
        check_eq("abort_rsp_hit", rsp_hit, 0);
        check_eq("abort_fill_addr", fill_addr, 0);
        check_eq("abort_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
        check_eq("abort_no_rsp", rsp_valid, 0);
        check_eq("abort_idle_ready", req_ready, 1);
        check_eq("abort_fill_idle", fill_req, 0);
    endtask

    initial begin
        logic [9:0] a;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; fill_valid = 1'b0; fill_data = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_hit", rsp_hit, 0);
        check_eq("rst_fill_req", fill_req, 0);
        check_eq("rst_fill_addr", fill_addr, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_ready", req_ready, 1);

        // Miss + refill, then a hit in the same line.
        do_read(10'h004, 16'h0, 0, 1'b0);
        do_read(10'h006, 16'h0, 0, 1'b0);

        // Write hit followed directly by a read of the same word.
        do_write(10'h005, 32'hDEADBEEF);
        do_read(10'h005, 16'h0, 0, 1'b0);
        check_eq("read_after_write", rsp_rdata, 32'hDEADBEEF);

        // Write miss: no allocation, no refill.
        do_write(10'h3F0, $urandom);
        @(posedge clk); #1;
        check_eq("wmiss_fill_idle", fill_req, 0);
        do_read(10'h3F0, 16'h0, 0, 1'b0);

        // Refill with gaps 1,0,0,1,1,0,1, then read the other words back.
        do_read(10'h104, 16'h0059, 7, 1'b0);
        do_read(10'h105, 16'h0, 0, 1'b0);
        do_read(10'h106, 16'h0, 0, 1'b0);
        do_read(10'h107, 16'h0, 0, 1'b0);

        // Reset after two beats aborts the refill; line stays invalid.
        read_abort(10'h204, 2);
        do_read(10'h204, 16'h0, 0, 1'b1);

        // Conflict in index 1.
        do_read(10'h004, 16'h0, 0, 1'b0);
        do_read(10'h084, 16'h0, 0, 1'b0);
        do_read(10'h004, 16'h0, 0, 1'b0);

        // Random mix over a small address window to get many hits/conflicts.
        for (int n = 0; n < 400; n++) begin
            a = 10'(($urandom_range(0, 1) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 4) do_write(a, $urandom);
            else                          do_read(a, 16'h0, 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
